plru_set_replacer: RTL



---
 rtl/repl_pkg.sv | 24 ++
 rtl/plru_set_replacer_if.sv | 32 +++
 rtl/repl_set_logic.sv | 68 ++++++
 rtl/plru_set_replacer.sv | 109 ++++++++++
 4 files changed

// File: rtl/repl_pkg.sv
// Shared definitions for the set replacement-state array: policy modes,
// tree sizing helpers and the flush FSM encoding.
package repl_pkg;

  localparam int REPL_MODE_PLRU = 0;
  localparam int REPL_MODE_RR   = 1;
  // Widest way mask the helper functions handle; callers slice down.
  localparam int MAX_WAYS       = 128;

  typedef enum logic {ST_IDLE, ST_FLUSH} flush_state_e;

  function automatic int plru_node_count(input int ways);
    return ways - 1;
  endfunction

  function automatic int state_width(input int ways, input int mode);
    return (mode == REPL_MODE_RR) ? $clog2(ways) : plru_node_count(ways);
  endfunction

  function automatic logic [MAX_WAYS-1:0] lowest_one(input logic [MAX_WAYS-1:0] mask);
    return mask & (~mask + 1'b1);
  endfunction

endpackage

// File: rtl/plru_set_replacer_if.sv
// Access / query / flush bus of the replacement-state array.
interface plru_set_replacer_if #(
  parameter int SET_COUNT = 16,
  parameter int WAY_COUNT = 4
);
  localparam int SET_W = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;

  logic                 access_vld_i;
  logic [SET_W-1:0]     access_set_i;
  logic [WAY_COUNT-1:0] access_way_mask_i;
  logic                 query_vld_i;
  logic [SET_W-1:0]     query_set_i;
  logic [WAY_COUNT-1:0] valid_mask_i;
  logic [WAY_COUNT-1:0] lock_mask_i;
  logic                 flush_i;
  logic                 flush_busy_o;
  logic                 victim_vld_o;
  logic [WAY_COUNT-1:0] victim_mask_o;
  logic                 victim_all_locked_o;

  modport master (
    output access_vld_i, access_set_i, access_way_mask_i,
    output query_vld_i, query_set_i, valid_mask_i, lock_mask_i, flush_i,
    input  flush_busy_o, victim_vld_o, victim_mask_o, victim_all_locked_o
  );

  modport slave (
    input  access_vld_i, access_set_i, access_way_mask_i,
    input  query_vld_i, query_set_i, valid_mask_i, lock_mask_i, flush_i,
    output flush_busy_o, victim_vld_o, victim_mask_o, victim_all_locked_o
  );
endinterface

// File: rtl/repl_set_logic.sv
// Combinational per-set policy: next state after an access and the policy
// victim of the current state (tree-PLRU or round-robin).
module repl_set_logic
  import repl_pkg::*;
#(
  parameter int WAY_COUNT = 4,
  parameter int MODE      = REPL_MODE_PLRU,
  parameter int STATE_W   = state_width(WAY_COUNT, MODE)
) (
  input  logic [STATE_W-1:0]   state_i,
  input  logic [WAY_COUNT-1:0] access_mask_i,
  output logic [STATE_W-1:0]   state_o,
  output logic [WAY_COUNT-1:0] victim_o
);
  localparam int IDX_W = $clog2(WAY_COUNT);
  localparam int NODES = plru_node_count(WAY_COUNT);

  logic [MAX_WAYS-WAY_COUNT-1:0] unused_acc_pad;
  logic [WAY_COUNT-1:0]          acc_oh;
  logic [IDX_W-1:0]              acc_idx;
  logic                          acc_any;

  assign {unused_acc_pad, acc_oh} = lowest_one(MAX_WAYS'(access_mask_i));
  assign acc_any = |acc_oh;

  always_comb begin
    acc_idx = '0;
    for (int i = 0; i < WAY_COUNT; i++)
      if (acc_oh[i]) acc_idx = IDX_W'(i);
  end

  if (MODE == REPL_MODE_RR) begin : g_rr
    always_comb begin
      state_o = state_i;
      if (acc_any && acc_idx == state_i) state_o = state_i + 1'b1;
      victim_o = WAY_COUNT'(1) << state_i;
    end
  end else begin : g_plru
    // Walk root-to-leaf; the way index MSB picks the child at the root.
    always_comb begin
      int               node;
      logic             b;
      logic [IDX_W-1:0] path;
      logic [IDX_W-1:0] vidx;
      state_o = state_i;
      path    = acc_idx;
      node    = 0;
      for (int l = 0; l < IDX_W; l++) begin
        b    = path[IDX_W-1];
        path = path << 1;
        for (int n = 0; n < NODES; n++)
          if (acc_any && n == node) state_o[n] = ~b;
        node = 2 * node + (b ? 2 : 1);
      end
      vidx = '0;
      node = 0;
      for (int l = 0; l < IDX_W; l++) begin
        b = 1'b0;
        for (int n = 0; n < NODES; n++)
          if (n == node) b = state_i[n];
        vidx = (vidx << 1) | IDX_W'(b);
        node = 2 * node + (b ? 2 : 1);
      end
      victim_o = WAY_COUNT'(1) << vidx;
    end
  end

endmodule

// File: rtl/plru_set_replacer.sv
// Multi-set replacement-state array: access updates, registered victim
// queries with invalid/lock priority, and a one-set-per-cycle flush walk.
module plru_set_replacer
  import repl_pkg::*;
#(
  parameter int SET_COUNT = 16,
  parameter int WAY_COUNT = 4,
  parameter int MODE      = REPL_MODE_PLRU
) (
  input  logic                clk,
  input  logic                rstn,
  plru_set_replacer_if.slave  bus
);
  localparam int SET_W   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1;
  localparam int STATE_W = state_width(WAY_COUNT, MODE);
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SET_COUNT - 1);

  logic [STATE_W-1:0] st [SET_COUNT];

  flush_state_e       fst, fst_nxt;
  logic [SET_W-1:0]   fcnt, fcnt_nxt;
  logic               clr, busy, en;
  logic [SET_W-1:0]   a_set, q_set;
  logic [STATE_W-1:0] a_state_nxt, q_state_unused;
  logic [WAY_COUNT-1:0] a_victim_unused, q_victim;
  logic [WAY_COUNT-1:0] free, unl, free_lo, unl_lo, sel_mask;
  logic [MAX_WAYS-WAY_COUNT-1:0] unused_free_pad, unused_unl_pad;
  logic                 sel_locked;

  assign busy  = (fst == ST_FLUSH);
  // A flush request also swallows the same-cycle access/query.
  assign en    = !busy && !bus.flush_i;
  assign a_set = (SET_COUNT == 1) ? '0 : bus.access_set_i;
  assign q_set = (SET_COUNT == 1) ? '0 : bus.query_set_i;
  assign bus.flush_busy_o = busy;

  repl_set_logic #(.WAY_COUNT(WAY_COUNT), .MODE(MODE)) u_access (
    .state_i(st[a_set]), .access_mask_i(bus.access_way_mask_i),
    .state_o(a_state_nxt), .victim_o(a_victim_unused)
  );

  repl_set_logic #(.WAY_COUNT(WAY_COUNT), .MODE(MODE)) u_query (
    .state_i(st[q_set]), .access_mask_i('0),
    .state_o(q_state_unused), .victim_o(q_victim)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fst  <= ST_IDLE;
      fcnt <= '0;
    end else begin
      fst  <= fst_nxt;
      fcnt <= fcnt_nxt;
    end
  end

  always_comb begin
    fst_nxt  = fst;
    fcnt_nxt = fcnt;
    clr      = 1'b0;
    if (bus.flush_i) begin
      fst_nxt  = ST_FLUSH;
      fcnt_nxt = '0;
    end else if (fst == ST_FLUSH) begin
      clr      = 1'b1;
      fcnt_nxt = fcnt + 1'b1;
      if (fcnt == LAST_SET) fst_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SET_COUNT; i++) st[i] <= '0;
    end else if (clr) begin
      st[fcnt] <= '0;
    end else if (bus.access_vld_i && en) begin
      st[a_set] <= a_state_nxt;
    end
  end

  always_comb begin
    free = ~bus.valid_mask_i & ~bus.lock_mask_i;
    unl  = ~bus.lock_mask_i;
    {unused_free_pad, free_lo} = lowest_one(MAX_WAYS'(free));
    {unused_unl_pad, unl_lo}   = lowest_one(MAX_WAYS'(unl));
    sel_mask   = '0;
    sel_locked = 1'b0;
    if (|free)                 sel_mask = free_lo;
    else if (|(q_victim & unl)) sel_mask = q_victim;
    else if (|unl)             sel_mask = unl_lo;
    else                       sel_locked = 1'b1;
  end

  // Mask and all-locked hold until the next accepted query.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.victim_vld_o        <= 1'b0;
      bus.victim_mask_o       <= '0;
      bus.victim_all_locked_o <= 1'b0;
    end else begin
      bus.victim_vld_o <= bus.query_vld_i && en;
      if (bus.query_vld_i && en) begin
        bus.victim_mask_o       <= sel_mask;
        bus.victim_all_locked_o <= sel_locked;
      end
    end
  end

endmodule
